// File: rtl/mapper_pkg.sv
// Shared mapper definitions: A12 filter states, IRQ write-strobe indices and
// the default A12 low-qualification length used by scanline counters.
package mapper_pkg;

   typedef enum logic [1:0] {
      F_HIGH  = 2'd0,
      F_LOW   = 2'd1,
      F_ARMED = 2'd2
   } a12_filt_e;

   localparam int IRQ_LATCH   = 0;
   localparam int IRQ_RELOAD  = 1;
   localparam int IRQ_DISABLE = 2;
   localparam int IRQ_ENABLE  = 3;

   localparam int A12_LOW_CYCLES_DEFAULT = 3;

endpackage

// File: rtl/a12_edge_filter.sv
// Synchronises raw PPU A12 onto M2 and emits a one-cycle clk_evt on a rising
// edge that follows a qualifying run of low samples.
module a12_edge_filter
   import mapper_pkg::*;
#(
   parameter int A12_LOW_CYCLES = A12_LOW_CYCLES_DEFAULT,
   parameter int SYNC_STAGES    = 2
) (
   input  logic m2,
   input  logic rst_n,
   input  logic a12_raw,
   output logic clk_evt
);

   localparam logic [1:0] LOW_MAX = 2'(A12_LOW_CYCLES);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   a12_s;
   a12_filt_e              state;
   logic [1:0]             low_cnt;

   assign a12_s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge m2 or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         state   <= F_HIGH;
         low_cnt <= 2'd0;
         clk_evt <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], a12_raw};
         clk_evt <= 1'b0;
         case (state)
            F_HIGH: begin
               if (!a12_s) begin
                  low_cnt <= 2'd1;
                  state   <= (LOW_MAX <= 2'd1) ? F_ARMED : F_LOW;
               end
            end
            F_LOW: begin
               // A high sample before the low run qualifies discards it silently.
               if (a12_s) begin
                  low_cnt <= 2'd0;
                  state   <= F_HIGH;
               end else begin
                  if (low_cnt != LOW_MAX) low_cnt <= low_cnt + 2'd1;
                  if (low_cnt + 2'd1 >= LOW_MAX) state <= F_ARMED;
               end
            end
            F_ARMED: begin
               if (a12_s) begin
                  low_cnt <= 2'd0;
                  clk_evt <= 1'b1;
                  state   <= F_HIGH;
               end
            end
            default: begin
               low_cnt <= 2'd0;
               state   <= F_HIGH;
            end
         endcase
      end
   end

endmodule

// File: rtl/mmc3_scanline_irq.sv
// MMC3-style scanline IRQ: counts filtered A12 rising edges on M2 and raises
// /IRQ when the counter reaches zero while enabled.
module mmc3_scanline_irq
   import mapper_pkg::*;
#(
   parameter int A12_LOW_CYCLES   = A12_LOW_CYCLES_DEFAULT,
   parameter int SYNC_STAGES      = 2,
   parameter int ZERO_LATCH_FIRES = 1
) (
   input  logic       m2,
   input  logic       rst_n,
   input  logic       ppu_a12,
   input  logic [7:0] cpu_data,
   input  logic       wr_latch,
   input  logic       wr_reload,
   input  logic       wr_disable,
   input  logic       wr_enable,
   output logic       irq_n,
   output logic       irq_pending,
   output logic [7:0] counter
);

   logic       clk_evt;
   logic [3:0] wr;
   logic [7:0] latch;
   logic       reload_flag;
   logic       enabled;
   logic       pending;
   logic       evt_reload;
   logic [7:0] cnt_evt;
   logic       fire;

   a12_edge_filter #(
      .A12_LOW_CYCLES (A12_LOW_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
   ) u_filt (
      .m2      (m2),
      .rst_n   (rst_n),
      .a12_raw (ppu_a12),
      .clk_evt (clk_evt)
   );

   always_comb begin
      wr              = '0;
      wr[IRQ_LATCH]   = wr_latch;
      wr[IRQ_RELOAD]  = wr_reload;
      wr[IRQ_DISABLE] = wr_disable;
      wr[IRQ_ENABLE]  = wr_enable;
   end

   // Reload path uses the latch as held this cycle, so a same-cycle latch
   // write only takes effect on the following event.
   always_comb begin
      evt_reload = (counter == 8'd0) || reload_flag;
      cnt_evt    = evt_reload ? latch : counter - 8'd1;
      fire       = clk_evt && (cnt_evt == 8'd0) &&
                   !(evt_reload && (latch == 8'd0) && (ZERO_LATCH_FIRES == 0));
   end

   always_ff @(posedge m2 or negedge rst_n) begin
      if (!rst_n) begin
         latch       <= 8'd0;
         counter     <= 8'd0;
         reload_flag <= 1'b0;
         enabled     <= 1'b0;
         pending     <= 1'b0;
      end else begin
         if (wr[IRQ_RELOAD]) begin
            counter     <= 8'd0;
            reload_flag <= 1'b1;
         end else begin
            if (clk_evt) begin
               counter     <= cnt_evt;
               reload_flag <= 1'b0;
            end
            if (wr[IRQ_LATCH]) latch <= cpu_data;
         end

         if (wr[IRQ_DISABLE]) begin
            enabled <= 1'b0;
            pending <= 1'b0;
         end else begin
            if (wr[IRQ_ENABLE]) enabled <= 1'b1;
            if (fire && !wr[IRQ_RELOAD] && (enabled || wr[IRQ_ENABLE]))
               pending <= 1'b1;
         end
      end
   end

   assign irq_n       = ~pending;
   assign irq_pending = pending;

endmodule

// File: tb/tb_mmc3_scanline_irq.sv
// Directed bench for mmc3_scanline_irq: new (ZERO_LATCH_FIRES=1) and old
// (ZERO_LATCH_FIRES=0) variants driven from the same stimulus.
module tb_mmc3_scanline_irq;
   import mapper_pkg::*;

   logic       m2 = 1'b0;
   logic       rst_n;
   logic       ppu_a12;
   logic [7:0] cpu_data;
   logic       wr_latch, wr_reload, wr_disable, wr_enable;
   logic       irq_n, irq_pending;
   logic [7:0] counter;
   logic       irq_n_old, irq_pending_old;
   logic [7:0] counter_old;

   int total = 0;
   int bad   = 0;

   always #5 m2 = ~m2;

   mmc3_scanline_irq dut (
      .m2 (m2), .rst_n (rst_n), .ppu_a12 (ppu_a12), .cpu_data (cpu_data),
      .wr_latch (wr_latch), .wr_reload (wr_reload),
      .wr_disable (wr_disable), .wr_enable (wr_enable),
      .irq_n (irq_n), .irq_pending (irq_pending), .counter (counter)
   );

   mmc3_scanline_irq #(.ZERO_LATCH_FIRES(0)) dut_old (
      .m2 (m2), .rst_n (rst_n), .ppu_a12 (ppu_a12), .cpu_data (cpu_data),
      .wr_latch (wr_latch), .wr_reload (wr_reload),
      .wr_disable (wr_disable), .wr_enable (wr_enable),
      .irq_n (irq_n_old), .irq_pending (irq_pending_old), .counter (counter_old)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge m2);
      #1;
   endtask

   task automatic strobe(input int idx, input logic [7:0] d);
      cpu_data = d;
      case (idx)
         IRQ_LATCH:   wr_latch   = 1'b1;
         IRQ_RELOAD:  wr_reload  = 1'b1;
         IRQ_DISABLE: wr_disable = 1'b1;
         default:     wr_enable  = 1'b1;
      endcase
   endtask

   task automatic clr;
      wr_latch = 1'b0; wr_reload = 1'b0; wr_disable = 1'b0; wr_enable = 1'b0;
   endtask

   task automatic wr(input int idx, input logic [7:0] d);
      strobe(idx, d);
      tick;
      clr;
   endtask

   task automatic pulse(input int low_n);
      ppu_a12 = 1'b0;
      repeat (low_n) tick;
      ppu_a12 = 1'b1;
      repeat (6) tick;
   endtask

   // Strobe lands on the same edge that consumes the resulting clk_evt.
   task automatic rise_with(input int low_n, input int idx, input logic [7:0] d);
      ppu_a12 = 1'b0;
      repeat (low_n) tick;
      ppu_a12 = 1'b1;
      repeat (3) tick;
      wr(idx, d);
      repeat (2) tick;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; ppu_a12 = 1'b1; cpu_data = 8'd0;
      clr;
      #12;
      chk("rst_irq_n", irq_n, 1);
      chk("rst_pending", irq_pending, 0);
      chk("rst_counter", counter, 0);
      #10 rst_n = 1'b1;
      repeat (4) tick;

      // basic countdown, latch=3
      wr(IRQ_LATCH, 8'd3);
      chk("latch_no_cnt", counter, 0);
      wr(IRQ_RELOAD, 8'd0);
      wr(IRQ_ENABLE, 8'd0);
      chk("en_no_irq", irq_n, 1);
      pulse(8); chk("cd_3", counter, 3);
      pulse(8); chk("cd_2", counter, 2);
      pulse(8); chk("cd_1", counter, 1);
      chk("cd_1_irq", irq_n, 1);
      ppu_a12 = 1'b0;
      repeat (8) tick;
      ppu_a12 = 1'b1;
      repeat (3) tick;
      chk("lat_pre_cnt", counter, 1);
      chk("lat_pre_irq", irq_n, 1);
      tick;
      chk("lat_cnt0", counter, 0);
      chk("lat_irq0", irq_n, 0);
      chk("lat_pend", irq_pending, 1);
      repeat (2) tick;
      pulse(8);
      chk("reload_3", counter, 3);
      chk("pend_hold", irq_n, 0);

      // acknowledge, glitch filter
      wr(IRQ_DISABLE, 8'd0);
      chk("ack_irq_n", irq_n, 1);
      chk("ack_pend", irq_pending, 0);
      pulse(2); chk("glitch2", counter, 3);
      pulse(3); chk("low3_dec", counter, 2);
      pulse(3); chk("low3_1", counter, 1);
      pulse(3); chk("dis_cnt0", counter, 0);
      chk("dis_no_irq", irq_n, 1);
      wr(IRQ_ENABLE, 8'd0);
      chk("en_at_0", irq_n, 1);

      // disable collides with firing event
      pulse(8); chk("c1_3", counter, 3);
      pulse(8);
      pulse(8); chk("c1_1", counter, 1);
      rise_with(8, IRQ_DISABLE, 8'd0);
      chk("coldis_cnt", counter, 0);
      chk("coldis_irq", irq_n, 1);

      // enable collides with firing event
      pulse(8);
      pulse(8);
      pulse(8); chk("c2_1", counter, 1);
      rise_with(8, IRQ_ENABLE, 8'd0);
      chk("colen_cnt", counter, 0);
      chk("colen_irq", irq_n, 0);
      wr(IRQ_DISABLE, 8'd0);

      // latch write collides with reload event
      wr(IRQ_LATCH, 8'd4);
      wr(IRQ_RELOAD, 8'd0);
      rise_with(8, IRQ_LATCH, 8'd9);
      chk("collat_old", counter, 4);
      pulse(8); chk("collat_dec", counter, 3);
      wr(IRQ_RELOAD, 8'd0);
      pulse(8); chk("collat_new", counter, 9);

      // reload collides with event
      wr(IRQ_ENABLE, 8'd0);
      rise_with(8, IRQ_RELOAD, 8'd0);
      chk("colrl_cnt", counter, 0);
      chk("colrl_irq", irq_n, 1);
      pulse(8); chk("colrl_flag", counter, 9);

      // latch = 0: new fires every event, old never
      wr(IRQ_DISABLE, 8'd0);
      wr(IRQ_LATCH, 8'd0);
      wr(IRQ_RELOAD, 8'd0);
      for (int i = 0; i < 10; i++) begin
         wr(IRQ_DISABLE, 8'd0);
         wr(IRQ_ENABLE, 8'd0);
         pulse(8);
         chk($sformatf("z_new_%0d", i), irq_n, 0);
         chk($sformatf("z_old_%0d", i), irq_n_old, 1);
      end
      chk("z_cnt", counter, 0);
      chk("z_cnt_old", counter_old, 0);

      // async reset while armed and pending
      wr(IRQ_LATCH, 8'd2);
      wr(IRQ_RELOAD, 8'd0);
      pulse(8);
      chk("pre_rst_cnt", counter, 2);
      chk("pre_rst_irq", irq_n, 0);
      ppu_a12 = 1'b0;
      repeat (8) tick;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_irq_n", irq_n, 1);
      chk("arst_pend", irq_pending, 0);
      chk("arst_cnt", counter, 0);
      ppu_a12 = 1'b1;
      #3 rst_n = 1'b1;
      wr(IRQ_LATCH, 8'd5);
      wr(IRQ_RELOAD, 8'd0);
      repeat (4) tick;
      chk("post_rst_noevt", counter, 0);
      pulse(2); chk("post_rst_g2", counter, 0);
      pulse(3); chk("post_rst_l3", counter, 5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mmc3_scanline_irq.md
Name: mmc3_scanline_irq

Overview:
- Synchronous MMC3-style scanline IRQ generator that sits downstream of the mapper register decoder.
- Consumes the decoded $C000/$C001/$E000/$E001 write strobes and raw PPU A12, and drives the cartridge /IRQ line to the CPU.
- Replaces the multi-edge A12/M2 counter logic with a single-clock design: A12 is synchronised and filtered on M2, and all state changes occur on rising M2.

Parameters:
- A12_LOW_CYCLES, 3, number of consecutive M2 samples with A12 low required to arm the next rising-edge clock event.
- SYNC_STAGES, 2, synchroniser depth for ppu_a12 (minimum 2).
- ZERO_LATCH_FIRES, 1, controls whether a reload to 0 asserts IRQ. 1 = asserts IRQ on every clock event while latch = 0 (new MMC3 behaviour). 0 = never asserts after a reload to 0 (old MMC3).

Ports:
- m2  input  1  CPU M2. This is the single clock; all state updates occur on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ppu_a12  input  1  raw PPU address bit 12, asynchronous to m2.
- cpu_data  input  8  CPU data captured with the write strobes.
- wr_latch  input  1  one-cycle strobe, $C000 even write: latch <= cpu_data.
- wr_reload  input  1  one-cycle strobe, $C001 odd write: request reload.
- wr_disable  input  1  one-cycle strobe, $E000 even write: disable IRQ and acknowledge.
- wr_enable  input  1  one-cycle strobe, $E001 odd write: enable IRQ.
- irq_n  output  1  active-low IRQ to the CPU. The top level converts this to open-drain (0 -> drive 0, 1 -> Z).
- irq_pending  output  1  status, equal to ~irq_n.
- counter  output  8  current counter value, for debug and verification.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - latch=0, counter=0, reload_flag=0, enabled=0, pending=0.
  - Filter state = F_HIGH, low_cnt=0, synchroniser chain = 0.
  - Outputs: irq_n=1, irq_pending=0, counter=0.
- Synchroniser: a12_s is ppu_a12 after SYNC_STAGES flops. There is no combinational path from ppu_a12 to any state.
- A12 filter FSM, with the low counter low_cnt as 2 bits saturating at A12_LOW_CYCLES:
  - F_HIGH: if a12_s=0, go to F_LOW with low_cnt=1.
  - F_LOW: if a12_s=1, go to F_HIGH with no event. Otherwise increment low_cnt; on reaching A12_LOW_CYCLES, go to F_ARMED.
  - F_ARMED: if a12_s=1, go to F_HIGH and emit clk_evt for exactly one cycle.
  - Any high sample in F_LOW resets arming. Short high glitches therefore produce at most one event, and only after a qualifying low period.
- Clock event (clk_evt=1):
  - If counter==0 or reload_flag=1: counter <= latch, and reload_flag <= 0.
  - Otherwise: counter <= counter-1, using 8-bit arithmetic; counter is never decremented below 0.
  - Fire condition: the new counter == 0, and not (latch==0 and ZERO_LATCH_FIRES==0 and the event took the reload path).
  - If the fire condition holds and enabled=1, pending <= 1.
- Register writes:
  - wr_latch: latch <= cpu_data. This does not alter counter.
  - wr_reload: counter <= 0 and reload_flag <= 1.
  - wr_disable: enabled <= 0 and pending <= 0. irq_n rises on the next edge.
  - wr_enable: enabled <= 1. This does not set pending, even if counter==0.
- Simultaneous events in one cycle:
  - wr_latch + clk_evt reload path: the reload uses the OLD latch value. The new latch applies from the next cycle.
  - wr_reload + clk_evt: the event is processed first, then the write is applied. Net result: counter=0, reload_flag=1, and no fire from that event.
  - wr_disable + clk_evt firing: disable wins, so pending=0 and enabled=0.
  - wr_enable + clk_evt firing: the event fires using the new enabled=1.
  - Multiple write strobes in one cycle cannot occur (address-decoded by the upstream block). If they do occur, priority is disable > enable and reload > latch.
- Latency:
  - ppu_a12 rising to clk_evt: SYNC_STAGES+1 cycles.
  - clk_evt to irq_n low: 1 cycle, registered.
- Pending:
  - Once set, pending holds through further events until wr_disable or reset.
  - Reset mid-operation clears everything immediately, regardless of filter state.

Decomposition:
- Shared package mapper_pkg holds:
  - filter state typedef (F_HIGH, F_LOW, F_ARMED);
  - write-strobe index constants (IRQ_LATCH, IRQ_RELOAD, IRQ_DISABLE, IRQ_ENABLE);
  - A12_LOW_CYCLES_DEFAULT.
- One sub-module, a12_edge_filter: contains the synchroniser and filter FSM, and outputs clk_evt. It is reusable by future MMC5 and VRC scanline blocks.

Test Plan:
- Reset and basic countdown: latch=3, reload, enable, then 5 clean A12 pulses (each with 8 low M2 cycles and 2 high) -> counter sequence 3,2,1,0. irq_n falls 1 cycle after the 4th clk_evt and stays low after the 5th (counter reloads to 3).
- Glitch filter: A12 low for only 2 M2 cycles between pulses -> no clk_evt for that pulse and the counter is unchanged. With 3 low cycles -> exactly one decrement.
- Acknowledge: with irq_n low, pulse wr_disable -> irq_n=1 next cycle. wr_enable then does not re-assert while the counter remains 0.
- Latch=0 case: ZERO_LATCH_FIRES=1 -> IRQ on every event. ZERO_LATCH_FIRES=0 -> irq_n stays 1 over 10 events.
- Collisions: wr_disable in the same cycle as a firing event -> irq_n stays 1. wr_latch=9 in the same cycle as a reload event with old latch=4 -> counter=4.
- Async reset asserted while the filter is in F_ARMED and pending=1 -> immediately irq_n=1 and counter=0. After release, the first A12 rise produces no event until 3 low samples have been seen.
